// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-lane parking occupancy counter.
// Lane FSM state encoding and the pulse popcount used by the delta adder.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN_A   = 3'd1,
        IN_AB  = 3'd2,
        IN_B   = 3'd3,
        OUT_B  = 3'd4,
        OUT_BA = 3'd5,
        OUT_A  = 3'd6
    } lane_state_t;

    localparam int MAX_LANES = 8;

    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/car_dir_fsm.sv
// One lane's A/B direction FSM producing registered entry/exit pulses.
// With PARKING_DEBOUNCE_EN defined, each sensor bit is debounced first.
module car_dir_fsm
    import parking_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic in_pulse,
    output logic out_pulse
);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("car_dir_fsm: DEB_CYCLES must be at least 1");
    end

    logic sa, sb;

`ifdef PARKING_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       raw, filt;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {a, b};

    // A filtered bit flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != filt[i]) begin
                    if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                        filt[i] <= raw[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign sa = filt[1];
    assign sb = filt[0];
`else
    assign sa = a;
    assign sb = b;
`endif

    lane_state_t state, state_nx;
    logic [1:0]  ab;

    assign ab = {sa, sb};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (ab == 2'b10) state_nx = IN_A;
                    else if (ab == 2'b01) state_nx = OUT_B;
            IN_A:   if (ab == 2'b11) state_nx = IN_AB;
                    else if (ab == 2'b00) state_nx = IDLE;
            IN_AB:  if (ab == 2'b01) state_nx = IN_B;
                    else if (ab == 2'b10) state_nx = IN_A;
            IN_B:   if (ab == 2'b00) state_nx = IDLE;
                    else if (ab == 2'b11) state_nx = IN_AB;
            OUT_B:  if (ab == 2'b11) state_nx = OUT_BA;
                    else if (ab == 2'b00) state_nx = IDLE;
            OUT_BA: if (ab == 2'b10) state_nx = OUT_A;
                    else if (ab == 2'b01) state_nx = OUT_B;
            OUT_A:  if (ab == 2'b00) state_nx = IDLE;
                    else if (ab == 2'b11) state_nx = OUT_BA;
            default: state_nx = IDLE;
        endcase
    end

    // Pulses fire on the same edge the FSM returns to IDLE from a completed path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_pulse  <= 1'b0;
            out_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            in_pulse  <= (state == IN_B)  && (ab == 2'b00);
            out_pulse <= (state == OUT_A) && (ab == 2'b00);
        end
    end

endmodule

// File: rtl/parking_multi_lane_counter.sv
// N-lane parking occupancy counter: per-lane direction FSMs feed a shared
// saturating counter with full/empty and sticky error flags. Option: PARKING_DEBOUNCE_EN.
module parking_multi_lane_counter
    import parking_pkg::*;
#(
    parameter int N_LANES    = 2,
    parameter int CAPACITY   = 100,
    parameter int DEB_CYCLES = 4,
    localparam int CW        = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    output logic [N_LANES-1:0] in_pulse,
    output logic [N_LANES-1:0] out_pulse,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               err_ovf,
    output logic               err_unf
);

    localparam int SW = CW + 5;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    function automatic logic [CW-1:0] sat_count(input logic signed [SW-1:0] s);
        if (s > CAP_S)
            return CW'(CAPACITY);
        else if (s < 0)
            return '0;
        else
            return s[CW-1:0];
    endfunction

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        car_dir_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .a         (a[i]),
            .b         (b[i]),
            .in_pulse  (in_pulse[i]),
            .out_pulse (out_pulse[i])
        );
    end

    // Stage p0: registered lane pulses netted into a signed delta and raw sum.
    logic [MAX_LANES-1:0]   in_ext_p0, out_ext_p0;
    logic signed [4:0]      delta_p0;
    logic signed [SW-1:0]   sum_p0;
    logic [CW-1:0]          next_p0;

    always_comb begin
        in_ext_p0                = '0;
        out_ext_p0               = '0;
        in_ext_p0[N_LANES-1:0]  = in_pulse;
        out_ext_p0[N_LANES-1:0] = out_pulse;
    end

    assign delta_p0 = $signed({1'b0, popcount(in_ext_p0)}) - $signed({1'b0, popcount(out_ext_p0)});
    assign sum_p0   = $signed({5'b0, count}) + $signed({{CW{delta_p0[4]}}, delta_p0});
    assign next_p0  = sat_count(sum_p0);

    // Stage p1: clamped count, status flags and sticky errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            count   <= next_p0;
            full    <= (next_p0 == CW'(CAPACITY));
            empty   <= (next_p0 == '0);
            err_ovf <= err_ovf | (sum_p0 > CAP_S);
            err_unf <= err_unf | (sum_p0 < 0);
        end
    end

endmodule

// File: tb/tb_parking_multi_lane_counter.sv
// Bench for parking_multi_lane_counter: two instances (CAPACITY 100 and 3) share
// the stimulus and are compared against a track-position occupancy model.
module tb_parking_multi_lane_counter;

    localparam int NL    = 2;
    localparam int CAP_B = 100;
    localparam int CAP_S = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] a, b;
    logic [NL-1:0] inp_b, outp_b, inp_s, outp_s;
    logic [6:0]    cnt_b;
    logic [1:0]    cnt_s;
    logic          full_b, empty_b, ovf_b, unf_b;
    logic          full_s, empty_s, ovf_s, unf_s;

    int checks   = 0;
    int failures = 0;

    // Model: each lane is a position on a track, +1..+3 heading in, -1..-3 heading out.
    int pos [NL];
    bit m_in [NL];
    bit m_out [NL];
    int mcnt [2];
    bit movf [2];
    bit munf [2];
    int caps [2] = '{CAP_B, CAP_S};

    always #5 clk = ~clk;

    parking_multi_lane_counter #(.N_LANES(NL), .CAPACITY(CAP_B), .DEB_CYCLES(4)) dut_big (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .in_pulse(inp_b), .out_pulse(outp_b), .count(cnt_b),
        .full(full_b), .empty(empty_b), .err_ovf(ovf_b), .err_unf(unf_b)
    );

    parking_multi_lane_counter #(.N_LANES(NL), .CAPACITY(CAP_S), .DEB_CYCLES(4)) dut_sml (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .in_pulse(inp_s), .out_pulse(outp_s), .count(cnt_s),
        .full(full_s), .empty(empty_s), .err_ovf(ovf_s), .err_unf(unf_s)
    );

    function automatic logic [1:0] pat(input int p);
        case (p)
            1, -3:   return 2'b10;
            2, -2:   return 2'b11;
            3, -1:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] car_ab(input int kind, input int s);
        case (kind)
            1: case (s) 0: return 2'b10; 1: return 2'b11; 2: return 2'b01; default: return 2'b00; endcase
            2: case (s) 0: return 2'b01; 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
            3: case (s) 0: return 2'b10; 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            pos[l] = 0; m_in[l] = 1'b0; m_out[l] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int net;
        int s;
        int d;
        logic [1:0] ab;
        net = 0;
        for (int l = 0; l < NL; l++) net = net + int'(m_in[l]) - int'(m_out[l]);
        for (int k = 0; k < 2; k++) begin
            s = mcnt[k] + net;
            if (s > caps[k]) begin
                mcnt[k] = caps[k]; movf[k] = 1'b1;
            end else if (s < 0) begin
                mcnt[k] = 0; munf[k] = 1'b1;
            end else begin
                mcnt[k] = s;
            end
        end
        for (int l = 0; l < NL; l++) begin
            ab = {a[l], b[l]};
            m_in[l] = 1'b0; m_out[l] = 1'b0;
            if (pos[l] == 0) begin
                if (ab == 2'b10) pos[l] = 1;
                else if (ab == 2'b01) pos[l] = -1;
            end else begin
                d = (pos[l] > 0) ? 1 : -1;
                if ((pos[l] == 3 || pos[l] == -3) && ab == 2'b00) begin
                    if (pos[l] > 0) m_in[l] = 1'b1; else m_out[l] = 1'b1;
                    pos[l] = 0;
                end else if (pos[l] != 3 && pos[l] != -3 && ab == pat(pos[l] + d)) begin
                    pos[l] = pos[l] + d;
                end else if (ab == pat(pos[l] - d)) begin
                    pos[l] = pos[l] - d;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NL-1:0] ein, eout;
        for (int l = 0; l < NL; l++) begin
            ein[l] = m_in[l]; eout[l] = m_out[l];
        end
        chk("in_pulse_big",  32'(inp_b),  32'(ein));
        chk("out_pulse_big", 32'(outp_b), 32'(eout));
        chk("in_pulse_sml",  32'(inp_s),  32'(ein));
        chk("out_pulse_sml", 32'(outp_s), 32'(eout));
        chk("count_big",     32'(cnt_b),  32'(mcnt[0]));
        chk("full_big",      32'(full_b), 32'(mcnt[0] == CAP_B));
        chk("empty_big",     32'(empty_b), 32'(mcnt[0] == 0));
        chk("ovf_big",       32'(ovf_b),  32'(movf[0]));
        chk("unf_big",       32'(unf_b),  32'(munf[0]));
        chk("count_sml",     32'(cnt_s),  32'(mcnt[1]));
        chk("full_sml",      32'(full_s), 32'(mcnt[1] == CAP_S));
        chk("empty_sml",     32'(empty_s), 32'(mcnt[1] == 0));
        chk("ovf_sml",       32'(ovf_s),  32'(movf[1]));
        chk("unf_sml",       32'(unf_s),  32'(munf[1]));
    endtask

    task automatic step(input logic [NL-1:0] av, input logic [NL-1:0] bv);
        a = av;
        b = bv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic lane0(input logic [1:0] ab);
        step({1'b0, ab[1]}, {1'b0, ab[0]});
    endtask

    task automatic lane0_car(input int kind);
        for (int s = 0; s < 4; s++) lane0(car_ab(kind, s));
    endtask

    task automatic do_reset();
        a = '0;
        b = '0;
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] ab0, ab1;
        int k0, k1;

        // Power-on reset
        a = '0; b = '0; rst = 1'b1;
        model_reset();
        #12;
        check_all();
        chk("reset_empty", 32'(empty_b), 32'd1);
        rst = 1'b0;

        // Clean entry on lane 0
        lane0(2'b10); lane0(2'b11); lane0(2'b01); lane0(2'b00);
        chk("entry_pulse", 32'(inp_b), 32'd1);
        lane0(2'b00);
        chk("entry_count", 32'(cnt_b), 32'd1);
        chk("entry_empty", 32'(empty_b), 32'd0);

        // Back-out leaves the count alone
        lane0_car(3);
        lane0(2'b00);
        chk("backout_count", 32'(cnt_b), 32'd1);

        // Saturation on the CAPACITY=3 instance
        lane0_car(1); lane0_car(1); lane0_car(1);
        lane0(2'b00);
        chk("sat_count", 32'(cnt_s), 32'd3);
        chk("sat_full",  32'(full_s), 32'd1);
        chk("sat_ovf",   32'(ovf_s), 32'd1);
        lane0_car(2);
        lane0(2'b00);
        chk("exit_count_sml", 32'(cnt_s), 32'd2);
        chk("exit_full_sml",  32'(full_s), 32'd0);
        chk("exit_ovf_sticky", 32'(ovf_s), 32'd1);

        // Reach count 5, then lane 0 enters while lane 1 exits on the same cycles
        lane0_car(1); lane0_car(1);
        lane0(2'b00);
        chk("pre_simul_count", 32'(cnt_b), 32'd5);
        step(2'b01, 2'b10); step(2'b11, 2'b11); step(2'b10, 2'b01); step(2'b00, 2'b00);
        chk("simul_in",  32'(inp_b), 32'd1);
        chk("simul_out", 32'(outp_b), 32'd2);
        step(2'b00, 2'b00);
        chk("simul_count", 32'(cnt_b), 32'd5);
        chk("simul_ovf",   32'(ovf_b), 32'd0);
        chk("simul_unf",   32'(unf_b), 32'd0);

        // Underflow from an empty lot
        do_reset();
        lane0_car(2);
        lane0(2'b00);
        chk("unf_count", 32'(cnt_b), 32'd0);
        chk("unf_flag",  32'(unf_b), 32'd1);

        // Reset in the middle of an entry drops the partial car
        lane0(2'b10); lane0(2'b11);
        do_reset();
        chk("rst_count", 32'(cnt_b), 32'd0);
        chk("rst_full",  32'(full_b), 32'd0);
        chk("rst_unf",   32'(unf_b), 32'd0);
        lane0(2'b01); lane0(2'b00);
        chk("rst_no_pulse", 32'(inp_b), 32'd0);
        lane0(2'b00);

        // Random raw sensor noise on both lanes
        for (int i = 0; i < 200; i++) begin
            step(NL'($urandom_range(0, 3)), NL'($urandom_range(0, 3)));
        end

        // Random well-formed car activity per lane
        for (int i = 0; i < 60; i++) begin
            k0 = $urandom_range(0, 3);
            k1 = $urandom_range(0, 3);
            for (int s = 0; s < 4; s++) begin
                ab0 = car_ab(k0, s);
                ab1 = car_ab(k1, s);
                step({ab1[1], ab0[1]}, {ab1[0], ab0[0]});
            end
        end
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
